// File: rtl/nixie_pkg.sv
// Shared constants for the nixie scan decoder: segment patterns (g..a),
// digit-select one-hot codes and the frame-assembly FSM encoding.
package nixie_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [2:0] AN_D0 = 3'b001;
  localparam logic [2:0] AN_D1 = 3'b010;
  localparam logic [2:0] AN_D2 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GOT2 = 2'd1,
    ST_GOT1 = 2'd2
  } state_t;

  function automatic logic an_onehot(input logic [2:0] an);
    return (an == AN_D0) || (an == AN_D1) || (an == AN_D2);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment (g..a) to nibble decoder.
// NIXIE_HEX_EN: when defined, the A..F glyphs are accepted as legal digits;
// otherwise they decode but are flagged as not ok.
module seg7_decode
  import nixie_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       ok
);

`ifdef NIXIE_HEX_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  // Pattern lookup; unknown glyphs report ok=0 with nibble 0.
  always_comb begin
    nibble = 4'h0;
    ok     = 1'b1;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: begin nibble = 4'hA; ok = HEX_EN; end
      SEG_B: begin nibble = 4'hB; ok = HEX_EN; end
      SEG_C: begin nibble = 4'hC; ok = HEX_EN; end
      SEG_D: begin nibble = 4'hD; ok = HEX_EN; end
      SEG_E: begin nibble = 4'hE; ok = HEX_EN; end
      SEG_F: begin nibble = 4'hF; ok = HEX_EN; end
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/nixie_scan_decoder.sv
// Decodes the 3-digit multiplexed display scan back into a 12-bit value and
// publishes it after STABLE_FRAMES identical consecutive frames.
// Optional build macro: NIXIE_HEX_EN (accept A..F glyphs, see seg7_decode).
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | hunting for an=100 (d2); other digits ignored
// ST_GOT2 | d2 captured, expecting an=010 (d1)
// ST_GOT1 | d1 captured, expecting an=001 (d0, frame end)
module nixie_scan_decoder
  import nixie_pkg::*;
#(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  an,
  input  logic [7:0]  leds,
  output logic [11:0] count,
  output logic        valid,
  output logic        locked,
  output logic        seg_err,
  output logic        seq_err
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  state_t      state;
  logic [3:0]  d2;
  logic [3:0]  d1;
  logic [11:0] last;
  logic [3:0]  run;

  logic [3:0]  nib;
  logic        pat_ok;
  logic        onehot;
  logic        dp_ok;
  logic        seg_bad;
  logic        seq_bad;
  logic [11:0] frame;
  logic [3:0]  run_upd;

  seg7_decode u_dec (
    .pattern (leds[6:0]),
    .nibble  (nib),
    .ok      (pat_ok)
  );

  // Per-sample error classification and the run count a completing frame would yield.
  always_comb begin
    onehot  = an_onehot(an);
    dp_ok   = (an == AN_D2) ? leds[7] : ~leds[7];
    seg_bad = ~(pat_ok & dp_ok);
    seq_bad = ~onehot
            | ((state == ST_GOT2) & (an != AN_D1))
            | ((state == ST_GOT1) & (an != AN_D0));
    frame   = {d2, d1, nib};
    if (frame == last)
      run_upd = (run == 4'd15) ? 4'd15 : run + 4'd1;
    else
      run_upd = 4'd1;
  end

  // Frame-assembly FSM, stability tracker and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      d2      <= 4'h0;
      d1      <= 4'h0;
      last    <= 12'h000;
      run     <= 4'd0;
      count   <= 12'h000;
      valid   <= 1'b0;
      locked  <= 1'b0;
      seg_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      valid   <= 1'b0;
      seg_err <= seg_bad;
      seq_err <= seq_bad;

      if (seg_bad || seq_bad) begin
        run    <= 4'd0;
        locked <= 1'b0;
      end

      if (!onehot || seg_bad) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (an == AN_D2) begin
              d2    <= nib;
              state <= ST_GOT2;
            end
          end
          ST_GOT2: begin
            if (an == AN_D1) begin
              d1    <= nib;
              state <= ST_GOT1;
            end else if (an == AN_D2) begin
              d2    <= nib;
              state <= ST_GOT2;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_GOT1: begin
            if (an == AN_D0) begin
              state <= ST_IDLE;
              run   <= run_upd;
              if (frame != last)
                last <= frame;
              if (run_upd >= SF) begin
                count  <= frame;
                valid  <= 1'b1;
                locked <= 1'b1;
              end else begin
                locked <= 1'b0;
              end
            end else if (an == AN_D2) begin
              d2    <= nib;
              state <= ST_GOT2;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nixie_scan_decoder.sv
// Directed bench for nixie_scan_decoder (STABLE_FRAMES = 2).
// Inputs change on the falling edge; outputs are checked 1 ns after the
// rising edge that sampled the stimulus.
module tb_nixie_scan_decoder;

  logic        clk;
  logic        reset;
  logic [2:0]  an;
  logic [7:0]  leds;
  logic [11:0] count;
  logic        valid;
  logic        locked;
  logic        seg_err;
  logic        seq_err;

  int checks;
  int failures;

  nixie_scan_decoder #(.STABLE_FRAMES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .an      (an),
    .leds    (leds),
    .count   (count),
    .valid   (valid),
    .locked  (locked),
    .seg_err (seg_err),
    .seq_err (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic samp(input logic [2:0] a, input logic [7:0] l);
    @(negedge clk);
    an   = a;
    leds = l;
    @(posedge clk);
    #1;
  endtask

  task automatic frame3(input logic [7:0] p2, input logic [7:0] p1, input logic [7:0] p0);
    samp(3'b100, p2);
    samp(3'b010, p1);
    samp(3'b001, p0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    an       = 3'b000;
    leds     = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 32'(count), 32'h000);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_seg_err", 32'(seg_err), 0);
    check_eq("rst_seq_err", 32'(seq_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // clean 0x123 scan
    frame3(8'h86, 8'h5B, 8'h4F);
    check_eq("f1_valid", 32'(valid), 0);
    check_eq("f1_locked", 32'(locked), 0);
    frame3(8'h86, 8'h5B, 8'h4F);
    check_eq("f2_valid", 32'(valid), 1);
    check_eq("f2_count", 32'(count), 32'h123);
    check_eq("f2_locked", 32'(locked), 1);
    check_eq("f2_seg_err", 32'(seg_err), 0);
    frame3(8'h86, 8'h5B, 8'h4F);
    check_eq("f3_valid", 32'(valid), 1);
    check_eq("f3_locked", 32'(locked), 1);

    // value change to 0x456
    frame3(8'hE6, 8'h6D, 8'h7D);
    check_eq("chg1_valid", 32'(valid), 0);
    check_eq("chg1_locked", 32'(locked), 0);
    check_eq("chg1_count", 32'(count), 32'h123);
    frame3(8'hE6, 8'h6D, 8'h7D);
    check_eq("chg2_valid", 32'(valid), 1);
    check_eq("chg2_count", 32'(count), 32'h456);
    check_eq("chg2_locked", 32'(locked), 1);

    // illegal glyph on d2
    samp(3'b100, 8'hC9);
    check_eq("ill_seg_err", 32'(seg_err), 1);
    check_eq("ill_seq_err", 32'(seq_err), 0);
    check_eq("ill_locked", 32'(locked), 0);
    check_eq("ill_count", 32'(count), 32'h456);
    samp(3'b010, 8'h5B);
    check_eq("hunt_seg_err", 32'(seg_err), 0);
    check_eq("hunt_seq_err", 32'(seq_err), 0);

    // order break, then non-one-hot an
    samp(3'b100, 8'h86);
    samp(3'b001, 8'h4F);
    check_eq("ord_seq_err", 32'(seq_err), 1);
    check_eq("ord_seg_err", 32'(seg_err), 0);
    samp(3'b011, 8'h06);
    check_eq("noh_seq_err", 32'(seq_err), 1);
    samp(3'b010, 8'h5B);
    samp(3'b001, 8'h4F);
    check_eq("idle_seq_err", 32'(seq_err), 0);

    // simultaneous segment and sequence errors
    samp(3'b100, 8'h86);
    samp(3'b001, 8'h49);
    check_eq("both_seg_err", 32'(seg_err), 1);
    check_eq("both_seq_err", 32'(seq_err), 1);

    // resync on an early d2
    samp(3'b100, 8'h86);
    samp(3'b010, 8'h5B);
    samp(3'b100, 8'h86);
    check_eq("rsy_seq_err", 32'(seq_err), 1);
    check_eq("rsy_seg_err", 32'(seg_err), 0);
    samp(3'b010, 8'h5B);
    samp(3'b001, 8'h4F);
    check_eq("rsy_f1_valid", 32'(valid), 0);
    frame3(8'h86, 8'h5B, 8'h4F);
    check_eq("rsy_f2_valid", 32'(valid), 1);
    check_eq("rsy_f2_count", 32'(count), 32'h123);

    // dp present on d0
    frame3(8'h86, 8'h5B, 8'hCF);
    check_eq("dp_seg_err", 32'(seg_err), 1);
    check_eq("dp_locked", 32'(locked), 0);

    // reset between d1 and d0
    samp(3'b100, 8'h86);
    samp(3'b010, 8'h5B);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_count", 32'(count), 32'h000);
    check_eq("mid_rst_locked", 32'(locked), 0);
    check_eq("mid_rst_valid", 32'(valid), 0);
    @(negedge clk);
    reset = 1'b0;
    samp(3'b001, 8'h4F);
    check_eq("post_rst_d0_seq", 32'(seq_err), 0);
    check_eq("post_rst_d0_valid", 32'(valid), 0);
    frame3(8'h86, 8'h5B, 8'h4F);
    check_eq("post_rst_f1_valid", 32'(valid), 0);
    frame3(8'h86, 8'h5B, 8'h4F);
    check_eq("post_rst_f2_valid", 32'(valid), 1);
    check_eq("post_rst_f2_count", 32'(count), 32'h123);

    // hex glyph on digit0
`ifdef NIXIE_HEX_EN
    frame3(8'h86, 8'h5B, 8'h77);
    check_eq("hex1_valid", 32'(valid), 0);
    check_eq("hex1_seg_err", 32'(seg_err), 0);
    frame3(8'h86, 8'h5B, 8'h77);
    check_eq("hex2_valid", 32'(valid), 1);
    check_eq("hex2_count", 32'(count), 32'h12A);
`else
    frame3(8'h86, 8'h5B, 8'h77);
    check_eq("hex_seg_err", 32'(seg_err), 1);
    check_eq("hex_valid", 32'(valid), 0);
    check_eq("hex_count", 32'(count), 32'h123);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
